// File: rtl/sevseg_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sevseg_pkg
// Description : Shared constants and helpers for the multiplexed seven-segment
//               driver. Provides the hex-to-segment table and the refresh
//               tick divisor calculation.
// Revision    : 1.0 - initial release
// ============================================================================
package sevseg_pkg;

    // Active-low segment bus with every segment and the decimal point dark
    localparam logic [7:0] SEG_OFF = 8'hFF;

    // Active-high {g,f,e,d,c,b,a} pattern for one hex digit
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg7;
        case (nibble)
            4'h0:    seg7 = 7'h3F;
            4'h1:    seg7 = 7'h06;
            4'h2:    seg7 = 7'h5B;
            4'h3:    seg7 = 7'h4F;
            4'h4:    seg7 = 7'h66;
            4'h5:    seg7 = 7'h6D;
            4'h6:    seg7 = 7'h7D;
            4'h7:    seg7 = 7'h07;
            4'h8:    seg7 = 7'h7F;
            4'h9:    seg7 = 7'h6F;
            4'hA:    seg7 = 7'h77;
            4'hB:    seg7 = 7'h7C;
            4'hC:    seg7 = 7'h39;
            4'hD:    seg7 = 7'h5E;
            4'hE:    seg7 = 7'h79;
            default: seg7 = 7'h71;
        endcase
        return seg7;
    endfunction

    // Clocks per PWM step; returns 0 when the configuration cannot be met
    // so the caller can reject it at elaboration.
    function automatic int tick_div(input int clk_hz, input int refresh_hz,
                                    input int digits, input int bright_w);
        longint den;
        if (digits < 1 || digits > 8 || bright_w < 1 || bright_w > 16 ||
            refresh_hz < 1 || clk_hz < 1) begin
            return 0;
        end
        den = longint'(refresh_hz) * longint'(digits) * (longint'(1) << bright_w);
        return int'(longint'(clk_hz) / den);
    endfunction

endpackage : sevseg_pkg
`default_nettype wire

// File: rtl/sevseg_mux_n_if.sv
`default_nettype none
// ============================================================================
// Interface   : sevseg_mux_n_if
// Description : Register-side load port and board-side anode/segment pins of
//               the multiplexed seven-segment driver.
// Revision    : 1.0 - initial release
// ============================================================================
interface sevseg_mux_n_if #(
    parameter int DIGITS   = 4,
    parameter int BRIGHT_W = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp;
    logic [DIGITS-1:0]     blank;
    logic [BRIGHT_W-1:0]   brightness;
    logic [DIGITS-1:0]     an;
    logic [7:0]            seg;
    logic                  frame_start;

    modport master (
        output load, value, dp, blank, brightness,
        input  an, seg, frame_start
    );

    modport slave (
        input  load, value, dp, blank, brightness,
        output an, seg, frame_start
    );
endinterface : sevseg_mux_n_if
`default_nettype wire

// File: rtl/sevseg_decode.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_decode
// Description : Combinational 4-bit hex to active-high 7-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_decode
    import sevseg_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);
    assign o_seg = hex_to_seg(i_nibble);
endmodule : sevseg_decode
`default_nettype wire

// File: rtl/sevseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : sevseg_mux_n
// Description : N-digit multiplexed seven-segment driver with PWM brightness,
//               per-digit blanking and frame-aligned double-buffered loads.
//               Optional build macro SEVSEG_LEADING_ZERO_BLANK_EN suppresses
//               the segments of leading zero digits.
// Revision    : 1.0 - initial release
// ============================================================================
module sevseg_mux_n
    import sevseg_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int DIGITS     = 4,
    parameter int BRIGHT_W   = 4
) (
    input  logic           clk,
    input  logic           rst,
    sevseg_mux_n_if.slave  bus
);

    localparam int c_TICK_DIV = tick_div(CLK_HZ, REFRESH_HZ, DIGITS, BRIGHT_W);
    localparam int c_PRE_W    = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
    localparam int c_DIG_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [c_PRE_W-1:0]  c_PRE_LAST = c_PRE_W'(c_TICK_DIV - 1);
    localparam logic [c_DIG_W-1:0]  c_DIG_LAST = c_DIG_W'(DIGITS - 1);
    localparam logic [BRIGHT_W-1:0] c_PWM_LAST = '1;

    generate
        if (c_TICK_DIV < 1) begin : g_bad_tick_div
            $error("sevseg_mux_n: clock too slow for REFRESH_HZ*DIGITS*2^BRIGHT_W");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Timebase: prescaler -> PWM step -> digit slot
    // ------------------------------------------------------------------
    logic [c_PRE_W-1:0]  r_presc;
    logic [BRIGHT_W-1:0] r_pwm;
    logic [c_DIG_W-1:0]  r_digit;
    logic                w_tick;
    logic                w_pwm_wrap;
    logic                w_frame_wrap;

    assign w_tick       = (r_presc == c_PRE_LAST);
    assign w_pwm_wrap   = w_tick && (r_pwm == c_PWM_LAST);
    assign w_frame_wrap = w_pwm_wrap && (r_digit == c_DIG_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_pwm   <= '0;
            r_digit <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + c_PRE_W'(1);
            if (w_tick) begin
                r_pwm <= r_pwm + BRIGHT_W'(1);
            end
            // Explicit wrap so non-power-of-two digit counts work
            if (w_pwm_wrap) begin
                r_digit <= (r_digit == c_DIG_LAST) ? '0 : r_digit + c_DIG_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Staging and display registers
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] r_stage_value;
    logic [DIGITS-1:0]   r_stage_dp;
    logic [DIGITS-1:0]   r_stage_blank;
    logic                r_pending;
    logic [4*DIGITS-1:0] r_value_q;
    logic [DIGITS-1:0]   r_dp_q;
    logic [DIGITS-1:0]   r_blank_q;
    logic                r_frame_start;

    logic                w_commit;
    logic [4*DIGITS-1:0] w_commit_value;
    logic [DIGITS-1:0]   w_commit_dp;
    logic [DIGITS-1:0]   w_commit_blank;

    // A load on the wrap cycle bypasses staging so it still lands this frame
    assign w_commit       = w_frame_wrap && (bus.load || r_pending);
    assign w_commit_value = bus.load ? bus.value : r_stage_value;
    assign w_commit_dp    = bus.load ? bus.dp    : r_stage_dp;
    assign w_commit_blank = bus.load ? bus.blank : r_stage_blank;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_stage_value <= '0;
            r_stage_dp    <= '0;
            r_stage_blank <= '0;
            r_pending     <= 1'b0;
            r_value_q     <= '0;
            r_dp_q        <= '0;
            r_blank_q     <= '0;
            r_frame_start <= 1'b0;
        end else begin
            if (bus.load) begin
                r_stage_value <= bus.value;
                r_stage_dp    <= bus.dp;
                r_stage_blank <= bus.blank;
            end
            if (w_frame_wrap) begin
                r_pending <= 1'b0;
            end else if (bus.load) begin
                r_pending <= 1'b1;
            end
            if (w_commit) begin
                r_value_q <= w_commit_value;
                r_dp_q    <= w_commit_dp;
                r_blank_q <= w_commit_blank;
            end
            r_frame_start <= w_frame_wrap;
        end
    end

    // ------------------------------------------------------------------
    // Leading-zero suppression mask
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] w_lz_mask;

`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
    logic [DIGITS-1:0] r_lz_mask;
    logic [DIGITS-1:0] w_lz_next;
    logic              w_seen_nz;

    // Scan from the most significant digit; digit 0 is never suppressed
    always_comb begin
        w_lz_next = '0;
        w_seen_nz = 1'b0;
        for (int d = DIGITS - 1; d > 0; d--) begin
            w_seen_nz    = w_seen_nz | (w_commit_value[4*d +: 4] != 4'h0);
            w_lz_next[d] = ~w_seen_nz;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_lz_mask <= '0;
        end else if (w_commit) begin
            r_lz_mask <= w_lz_next;
        end
    end

    assign w_lz_mask = r_lz_mask;
`else
    assign w_lz_mask = '0;
`endif

    // ------------------------------------------------------------------
    // Active digit selection and output registers
    // ------------------------------------------------------------------
    logic [3:0]        w_nibble;
    logic              w_dp_sel;
    logic              w_blank_sel;
    logic              w_lz_sel;
    logic [6:0]        w_seg7;
    logic              w_pwm_on;
    logic [DIGITS-1:0] w_an_next;
    logic [7:0]        w_seg_next;
    logic [DIGITS-1:0] r_an;
    logic [7:0]        r_seg;

    always_comb begin
        w_nibble    = 4'h0;
        w_dp_sel    = 1'b0;
        w_blank_sel = 1'b0;
        w_lz_sel    = 1'b0;
        for (int d = 0; d < DIGITS; d++) begin
            if (r_digit == c_DIG_W'(d)) begin
                w_nibble    = r_value_q[4*d +: 4];
                w_dp_sel    = r_dp_q[d];
                w_blank_sel = r_blank_q[d];
                w_lz_sel    = w_lz_mask[d];
            end
        end
    end

    sevseg_decode u_decode (
        .i_nibble (w_nibble),
        .o_seg    (w_seg7)
    );

    // Brightness is used live so duty changes take effect immediately
    assign w_pwm_on = (r_pwm < bus.brightness);

    always_comb begin
        w_an_next = '1;
        for (int d = 0; d < DIGITS; d++) begin
            if ((r_digit == c_DIG_W'(d)) && w_pwm_on && !w_blank_sel) begin
                w_an_next[d] = 1'b0;
            end
        end
    end

    // Suppressed leading zeros keep the anode driven so a set dp stays visible
    assign w_seg_next = ~{w_dp_sel, (w_lz_sel ? 7'h00 : w_seg7)};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_an  <= '1;
            r_seg <= SEG_OFF;
        end else begin
            r_an  <= w_an_next;
            r_seg <= w_seg_next;
        end
    end

    assign bus.an          = r_an;
    assign bus.seg         = r_seg;
    assign bus.frame_start = r_frame_start;

endmodule : sevseg_mux_n
`default_nettype wire

// File: tb/tb_sevseg_mux_n.sv
`default_nettype none
// ============================================================================
// Module      : tb_sevseg_mux_n
// Description : Scoreboard bench for sevseg_mux_n: expected whole-frame
//               pictures are queued by the stimulus and checked per frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sevseg_mux_n;

    localparam int c_SLOT  = 32;
    localparam int c_FRAME = 128;

    typedef struct packed {
        logic [3:0][7:0] seg;  // expected active-low segment bus per digit
        logic [3:0][7:0] low;  // clocks per slot with the digit's anode low
    } rec_t;

    localparam logic [6:0] HEX7 [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sevseg_mux_n_if #(.DIGITS(4), .BRIGHT_W(4)) bus ();

    sevseg_mux_n #(
        .CLK_HZ     (3200),
        .REFRESH_HZ (25),
        .DIGITS     (4),
        .BRIGHT_W   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int   n_compared   = 0;
    int   n_mismatched = 0;
    rec_t sb_q[$];
    bit   mon_en = 1'b0;

    logic [15:0] m_value;
    logic [3:0]  m_dp;
    logic [3:0]  m_blank;
    int          m_bright;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Picture of one frame from the last loaded data and brightness
    function automatic rec_t model(input logic [15:0] v, input logic [3:0] dpv,
                                   input logic [3:0] bl, input int b);
        rec_t       r;
        logic [3:0] nib;
        logic [6:0] segs;
        r = '0;
        for (int d = 0; d < 4; d++) begin
            nib  = 4'((v >> (4 * d)) & 16'hF);
            segs = HEX7[nib];
`ifdef SEVSEG_LEADING_ZERO_BLANK_EN
            if (d > 0 && (v >> (4 * d)) == 16'h0) segs = 7'h00;
`endif
            r.seg[d] = ~{dpv[d], segs};
            r.low[d] = bl[d] ? 8'd0 : 8'(2 * b);
        end
        return r;
    endfunction

    // Monitor: one frame window = 128 clocks following a frame_start pulse
    initial begin : monitor
        rec_t exp_r;
        rec_t obs;
        bit   have;
        int   unstable, other_an, fs_err, d;
        wait (mon_en);
        forever begin
            have = (sb_q.size() > 0);
            if (have) exp_r = sb_q.pop_front();
            obs = '0;
            unstable = 0; other_an = 0; fs_err = 0;
            for (int i = 0; i < c_FRAME; i++) begin
                @(negedge clk);
                d = i / c_SLOT;
                if (i % c_SLOT == 0) obs.seg[d] = bus.seg;
                else if (bus.seg !== obs.seg[d]) unstable++;
                if (bus.an[d] === 1'b0) obs.low[d] = obs.low[d] + 8'd1;
                if ((bus.an | (4'b0001 << d)) !== 4'hF) other_an++;
                if (bus.frame_start !== (i == c_FRAME - 1)) fs_err++;
            end
            if (have) begin
                for (int k = 0; k < 4; k++) begin
                    check($sformatf("seg_d%0d", k), 32'(obs.seg[k]), 32'(exp_r.seg[k]));
                    check($sformatf("an_low_clk_d%0d", k), 32'(obs.low[k]), 32'(exp_r.low[k]));
                end
                check("seg_unstable_in_slot", unstable, 0);
                check("inactive_anode_low", other_an, 0);
                check("frame_start_timing", fs_err, 0);
            end
        end
    end

    task automatic run_frame(input int k);
        int          ja, jb, nb, mode;
        logic [15:0] va, vb;
        logic [3:0]  da, db, ba, bb;
        ja = -1; jb = -1;
        va = 16'($urandom); vb = 16'($urandom);
        da = 4'($urandom);  db = 4'($urandom);
        ba = 4'($urandom);  bb = 4'($urandom);
        nb = $urandom_range(0, 15);
        case (k)
            0: begin ja = 10;  va = 16'h8F10; da = 0; ba = 0; nb = 15; end
            1: begin ja = 5;   va = 16'h1111; da = 0; ba = 0;
                     jb = 70;  vb = 16'h2222; db = 0; bb = 0; nb = 4; end
            2: begin jb = 127; vb = 16'h3C5A; db = 0; bb = 0; nb = 9; end
            3: begin ja = 20;  da = 4'b0001; ba = 4'b0100; nb = 4; end
            4: begin nb = 0; end
            5: begin ja = 3;   va = 16'h0042; da = 0; ba = 0; nb = 15; end
            6: begin ja = 100; va = 16'h0000; da = 0; ba = 0; nb = 15; end
            default: begin
                mode = $urandom_range(0, 3);
                if (mode == 1) ja = $urandom_range(0, 126);
                if (mode == 2) begin ja = $urandom_range(0, 60); jb = $urandom_range(61, 127); end
                if (mode == 3) jb = 127;
            end
        endcase
        for (int j = 0; j < c_FRAME; j++) begin
            // Non-load cycles carry junk data that must never be captured
            bus.load  = 1'b0;
            bus.value = 16'($urandom);
            bus.dp    = 4'($urandom);
            bus.blank = 4'($urandom);
            if (j == ja) begin
                bus.load = 1'b1; bus.value = va; bus.dp = da; bus.blank = ba;
                m_value = va; m_dp = da; m_blank = ba;
            end
            if (j == jb) begin
                bus.load = 1'b1; bus.value = vb; bus.dp = db; bus.blank = bb;
                m_value = vb; m_dp = db; m_blank = bb;
            end
            if (j == c_FRAME - 1) begin
                bus.brightness = 4'(nb);
                m_bright = nb;
                sb_q.push_back(model(m_value, m_dp, m_blank, m_bright));
            end
            @(negedge clk);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        int found, cnt;
        bus.load = 1'b0; bus.value = '0; bus.dp = '0; bus.blank = '0;
        bus.brightness = 4'd15;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_an", 32'(bus.an), 32'hF);
        check("reset_seg", 32'(bus.seg), 32'hFF);
        check("reset_frame_start", 32'(bus.frame_start), 0);
        rst = 1'b0;

        @(negedge clk);
        bus.load = 1'b1; bus.value = 16'h8F10;
        @(negedge clk);
        bus.load = 1'b0;
        found = 0;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin found = 1; break; end
        end
        check("first_frame_seen", found, 1);

        // Reset in the middle of a frame with non-zero data displayed
        repeat (40) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midframe_rst_an", 32'(bus.an), 32'hF);
        check("midframe_rst_seg", 32'(bus.seg), 32'hFF);
        check("midframe_rst_frame_start", 32'(bus.frame_start), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        for (int n = 1; n <= 400; n++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin cnt = n; break; end
        end
        check("rst_to_frame_start_clk", cnt, c_FRAME);

        // Display registers were cleared, so the first frame shows zeros
        m_value = '0; m_dp = '0; m_blank = '0; m_bright = 15;
        sb_q.push_back(model(m_value, m_dp, m_blank, m_bright));
        mon_en = 1'b1;

        for (int k = 0; k < 24; k++) run_frame(k);
        bus.load = 1'b0;

        repeat (c_FRAME + 4) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule : tb_sevseg_mux_n
`default_nettype wire
